// File: rtl/psum_drain_pkg.sv
// Shared definitions for the psum drain: FSM state encoding, requant shift width,
// and the lanes-per-word derivation.
package psum_drain_pkg;

  localparam int unsigned QS_WIDTH = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Number of requantized results packed into one output word.
  function automatic int unsigned pack_n(input int unsigned out_w, input int unsigned data_w);
    return out_w / data_w;
  endfunction

endpackage

// File: rtl/psum_requant.sv
// Combinational requantizer: round half up, arithmetic shift right by qs, then
// saturate to a signed or unsigned DATA_WIDTH range.
// Ports:
//   psum    signed PSUM_WIDTH partial sum
//   qs      right-shift amount (0 = no rounding, no shift)
//   sgn     1: saturate to signed range, 0: saturate to unsigned range
//   data_c  requantized DATA_WIDTH result
module psum_requant
  import psum_drain_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PSUM_WIDTH = 32
) (
  input  logic [PSUM_WIDTH-1:0] psum,
  input  logic [QS_WIDTH-1:0]   qs,
  input  logic                  sgn,
  output logic [DATA_WIDTH-1:0] data_c
);

  // One extra bit so the rounding add cannot overflow.
  localparam int unsigned EW = PSUM_WIDTH + 1;
  localparam logic signed [EW-1:0] SMAX = EW'((64'd1 << (DATA_WIDTH - 1)) - 64'd1);
  localparam logic signed [EW-1:0] SMIN = ~SMAX;
  localparam logic signed [EW-1:0] UMAX = EW'((64'd1 << DATA_WIDTH) - 64'd1);

  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] rnd;
  logic signed [EW-1:0] sum;
  logic signed [EW-1:0] shd;

  // Round, shift, saturate.
  always_comb begin
    ext = {psum[PSUM_WIDTH-1], psum};
    rnd = '0;
    if (qs != '0) begin
      rnd = EW'(1) << (qs - QS_WIDTH'(1));
    end
    sum    = ext + rnd;
    shd    = sum >>> qs;
    data_c = shd[DATA_WIDTH-1:0];
    if (sgn) begin
      if (shd > SMAX) begin
        data_c = SMAX[DATA_WIDTH-1:0];
      end else if (shd < SMIN) begin
        data_c = SMIN[DATA_WIDTH-1:0];
      end
    end else begin
      if (shd[EW-1]) begin
        data_c = '0;
      end else if (shd > UMAX) begin
        data_c = UMAX[DATA_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/psum_drain.sv
// Read-out end of the PE psum shift chain. Shifts the chain N_PEs times, requantizes
// each arriving psum, packs PACK_N results per word and hands words to the output
// buffer over valid/ready.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   start                    begin a drain (ignored unless idle)
//   base_addr, quant_shift,
//   out_sign                 drain configuration, captured on accepted start
//   shift                    advance the psum chain; psum_in is captured in the same cycle
//   psum_in                  last PE's psum
//   out_valid/out_ready      output word handshake
//   out_data, out_addr       packed word (lane 0 = first captured) and its address
//   busy, done               drain in progress / one-cycle completion pulse
module psum_drain
  import psum_drain_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PSUM_WIDTH = 32,
  parameter int unsigned N_PEs      = 16,
  parameter int unsigned OUT_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [QS_WIDTH-1:0]   quant_shift,
  input  logic                  out_sign,
  output logic                  shift,
  input  logic [PSUM_WIDTH-1:0] psum_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned PACK_N = pack_n(OUT_WIDTH, DATA_WIDTH);
  localparam int unsigned CNT_W  = $clog2(N_PEs + 1);
  localparam int unsigned LANE_W = (PACK_N > 1) ? $clog2(PACK_N) : 1;

  state_t                  state_q;
  state_t                  state_d;
  logic [QS_WIDTH-1:0]     qs_q;
  logic                    sign_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [CNT_W-1:0]        cap_q;
  logic [LANE_W-1:0]       lane_q;
  logic [OUT_WIDTH-1:0]    pack_q;
  logic [OUT_WIDTH-1:0]    pack_next;
  logic [DATA_WIDTH-1:0]   q_c;
  logic                    start_acc;
  logic                    last_lane;
  logic                    cap_last;

  assign start_acc = (state_q == ST_IDLE) && start;
  assign last_lane = (lane_q == LANE_W'(PACK_N - 1));
  assign cap_last  = (cap_q == CNT_W'(N_PEs - 1));

  // Combinational so a full output register stalls the chain in the same cycle
  // out_ready is seen low; only the capture that completes a word ever waits.
  assign shift = (state_q == ST_DRAIN) && !(last_lane && out_valid && !out_ready);

  psum_requant #(
    .DATA_WIDTH (DATA_WIDTH),
    .PSUM_WIDTH (PSUM_WIDTH)
  ) u_requant (
    .psum   (psum_in),
    .qs     (qs_q),
    .sgn    (sign_q),
    .data_c (q_c)
  );

  // Current partial word with this cycle's result dropped into its lane.
  always_comb begin
    pack_next = pack_q;
    pack_next[lane_q*DATA_WIDTH +: DATA_WIDTH] = q_c;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_DRAIN;
      ST_DRAIN: if (shift && cap_last) state_d = ST_FLUSH;
      ST_FLUSH: if (out_valid && out_ready) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Config capture, capture/lane counters, packer, output register, status.
  always_ff @(posedge clk) begin
    if (reset) begin
      qs_q      <= '0;
      sign_q    <= 1'b0;
      addr_q    <= '0;
      cap_q     <= '0;
      lane_q    <= '0;
      pack_q    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (start_acc) begin
        qs_q   <= quant_shift;
        sign_q <= out_sign;
        addr_q <= base_addr;
        cap_q  <= '0;
        lane_q <= '0;
        pack_q <= '0;
      end else if (shift) begin
        cap_q  <= cap_q + CNT_W'(1);
        lane_q <= last_lane ? '0 : lane_q + LANE_W'(1);
        pack_q <= last_lane ? '0 : pack_next;
      end

      // A completed word may replace one being accepted in the same cycle.
      if (shift && last_lane) begin
        out_valid <= 1'b1;
        out_data  <= pack_next;
        out_addr  <= addr_q;
        addr_q    <= addr_q + ADDR_WIDTH'(1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      busy <= (state_d == ST_DRAIN) || (state_d == ST_FLUSH);
      done <= (state_d == ST_DONE);
    end
  end

endmodule

// File: tb/tb_psum_drain.sv
// Bench for psum_drain: directed table of requant vectors, multi-cycle corner
// sequences (stall, ignored start, mid-drain reset, address wrap) and randomized drains
// against a behavioural model.
module tb_psum_drain;

  localparam int unsigned NPE = 16;

  logic        clk;
  logic        reset;
  logic        start;
  logic [9:0]  base_addr;
  logic [4:0]  quant_shift;
  logic        out_sign;
  logic        shift;
  logic [31:0] psum_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [9:0]  out_addr;
  logic        busy;
  logic        done;

  psum_drain #(
    .DATA_WIDTH (8),
    .PSUM_WIDTH (32),
    .N_PEs      (NPE),
    .OUT_WIDTH  (32),
    .ADDR_WIDTH (10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .quant_shift (quant_shift),
    .out_sign    (out_sign),
    .shift       (shift),
    .psum_in     (psum_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_addr    (out_addr),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PE chain: pe_vals[p] is PE[p]; PE[NPE-1] sits at the chain output.
  logic signed [31:0] pe_vals [NPE];
  logic signed [31:0] chain   [NPE];
  logic               load;

  always @(posedge clk) begin
    if (load) begin
      chain <= pe_vals;
    end else if (shift) begin
      for (int i = NPE - 1; i > 0; i--) chain[i] <= chain[i-1];
      chain[0] <= 32'sd0;
    end
  end
  assign psum_in = chain[NPE-1];

  // Per-cycle observer (negedge): shifts, done pulses, accepted words, hold stability.
  int          cyc = 0;
  int          shifts = 0;
  int          dones = 0;
  int          done_cyc = 0;
  int          stab_bad = 0;
  logic [31:0] got_d [$];
  logic [9:0]  got_a [$];
  logic        hold_prev = 1'b0;
  logic [31:0] prev_d;
  logic [9:0]  prev_a;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      hold_prev = 1'b0;
    end else begin
      if (shift) shifts = shifts + 1;
      if (done) begin
        dones    = dones + 1;
        done_cyc = cyc;
      end
      if (hold_prev && (!out_valid || out_data != prev_d || out_addr != prev_a))
        stab_bad = stab_bad + 1;
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        got_a.push_back(out_addr);
      end
      hold_prev = out_valid && !out_ready;
      prev_d    = out_data;
      prev_a    = out_addr;
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference requantizer: floor((p + half) / 2^qs), then clamp.
  function automatic logic [7:0] ref_q(input int p, input int qs, input bit sgn);
    longint v;
    longint lo;
    longint hi;
    v = longint'(p);
    if (qs > 0) v = v + (longint'(1) << (qs - 1));
    v  = v >>> qs;
    lo = sgn ? -128 : 0;
    hi = sgn ? 127 : 255;
    if (v < lo) v = lo;
    if (v > hi) v = hi;
    return 8'(v);
  endfunction

  // One drain. mode: 0 ready=1, 1 random ready, 2 ten-cycle stall after first word.
  // inject: 0 none, 1 start pulse mid-drain with other config, 2 reset mid-drain.
  task automatic drain(input int mode, input logic [9:0] base, input logic [4:0] qs,
                       input logic sgn, input int inject);
    int          s0, d0, g0, st0, c0, stall;
    bit          seen_v, released, aborted;
    logic [7:0]  r [NPE];
    logic [31:0] ew;
    s0 = shifts; d0 = dones; g0 = got_d.size(); st0 = stab_bad;
    seen_v = 0; released = 0; aborted = 0; stall = 0;
    @(posedge clk); #1;
    load = 1'b1; start = 1'b1; base_addr = base; quant_shift = qs; out_sign = sgn;
    out_ready = 1'b1;
    c0 = cyc + 1;
    for (int cy = 0; cy < 400; cy++) begin
      @(posedge clk); #1;
      load  = 1'b0;
      start = 1'b0;
      if (dones != d0) break;
      if (mode == 1) begin
        out_ready = 1'($urandom_range(0, 1));
      end else if (mode == 2) begin
        if (!seen_v && out_valid) begin
          seen_v = 1;
          stall  = 10;
        end
        if (stall > 0) begin
          out_ready = 1'b0;
          stall--;
        end else begin
          out_ready = 1'b1;
          if (seen_v && !released) begin
            released = 1;
            chk("stall_shifts", 64'(shifts - s0), 64'd7);
            chk("stall_hold_valid", 64'(out_valid), 64'd1);
            chk("stall_hold_addr", 64'(out_addr), 64'(base));
          end
        end
      end else begin
        out_ready = 1'b1;
      end
      if (cy == 0) chk("busy_after_start", 64'(busy), 64'd1);
      if (inject == 1 && cy == 5) begin
        chk("busy_mid_drain", 64'(busy), 64'd1);
        start = 1'b1; base_addr = base ^ 10'h155; quant_shift = qs ^ 5'h07; out_sign = !sgn;
      end
      if (inject == 2 && cy == 6) reset = 1'b1;
      if (inject == 2 && cy == 7) begin
        reset = 1'b0;
        chk("rst_shift", 64'(shift), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        aborted = 1;
        break;
      end
    end
    if (aborted) begin
      repeat (25) @(posedge clk);
      #1;
      chk("no_done_after_reset", 64'(dones - d0), 64'd0);
      return;
    end
    chk("done_seen", 64'(dones - d0), 64'd1);
    if (mode == 0) chk("done_cycle", 64'(done_cyc - c0), 64'd18);
    chk("shift_count", 64'(shifts - s0), 64'd16);
    chk("hold_stable", 64'(stab_bad - st0), 64'd0);
    chk("word_count", 64'(got_d.size() - g0), 64'd4);
    for (int k = 0; k < NPE; k++) r[k] = ref_q(pe_vals[NPE-1-k], int'(qs), sgn);
    for (int w = 0; w < 4; w++) begin
      ew = {r[4*w+3], r[4*w+2], r[4*w+1], r[4*w]};
      if (g0 + w < got_d.size()) begin
        chk("word_data", 64'(got_d[g0+w]), 64'(ew));
        chk("word_addr", 64'(got_a[g0+w]), 64'(10'(base + 10'(w))));
      end
    end
  endtask

  typedef struct packed {
    logic [31:0] psum;
    logic [4:0]  qs;
    logic        sgn;
    logic [7:0]  exp;
  } vec_t;

  vec_t vt [22];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int g;
    vt[0]  = '{32'sd6,           5'd2,  1'b1, 8'h02};
    vt[1]  = '{-32'sd6,          5'd2,  1'b1, 8'hFF};
    vt[2]  = '{32'sd5,           5'd1,  1'b1, 8'h03};
    vt[3]  = '{32'sd300,         5'd0,  1'b1, 8'h7F};
    vt[4]  = '{32'sd300,         5'd0,  1'b0, 8'hFF};
    vt[5]  = '{-32'sd300,        5'd0,  1'b1, 8'h80};
    vt[6]  = '{-32'sd300,        5'd0,  1'b0, 8'h00};
    vt[7]  = '{32'sd127,         5'd0,  1'b1, 8'h7F};
    vt[8]  = '{32'sd128,         5'd0,  1'b1, 8'h7F};
    vt[9]  = '{-32'sd128,        5'd0,  1'b1, 8'h80};
    vt[10] = '{-32'sd129,        5'd0,  1'b1, 8'h80};
    vt[11] = '{32'sd255,         5'd0,  1'b0, 8'hFF};
    vt[12] = '{32'sd256,         5'd0,  1'b0, 8'hFF};
    vt[13] = '{-32'sd1,          5'd0,  1'b0, 8'h00};
    vt[14] = '{32'sd1021,        5'd2,  1'b0, 8'hFF};
    vt[15] = '{32'sd1017,        5'd2,  1'b0, 8'hFE};
    vt[16] = '{-32'sd5,          5'd1,  1'b1, 8'hFE};
    vt[17] = '{-32'sd7,          5'd2,  1'b1, 8'hFE};
    vt[18] = '{32'sh7FFFFFFF,    5'd31, 1'b1, 8'h01};
    vt[19] = '{32'sh80000000,    5'd31, 1'b1, 8'hFF};
    vt[20] = '{32'sd100,         5'd3,  1'b0, 8'h0D};
    vt[21] = '{-32'sd100,        5'd3,  1'b1, 8'hF4};

    reset = 1'b1; start = 1'b0; load = 1'b0; out_ready = 1'b1;
    base_addr = '0; quant_shift = '0; out_sign = 1'b0;
    for (int i = 0; i < NPE; i++) pe_vals[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_shift", 64'(shift), 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_data", 64'(out_data), 64'd0);
    chk("reset_out_addr", 64'(out_addr), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    reset = 1'b0;

    // Psums 1..16, PE15 drained first.
    for (int i = 0; i < NPE; i++) pe_vals[i] = 32'(i + 1);
    g = got_d.size();
    drain(0, 10'h040, 5'd0, 1'b1, 0);
    if (got_d.size() > g) chk("ramp_word0", 64'(got_d[g]), 64'h0D0E0F10);

    // Requant table: every PE carries the vector psum.
    for (int v = 0; v < 22; v++) begin
      for (int i = 0; i < NPE; i++) pe_vals[i] = vt[v].psum;
      g = got_d.size();
      drain(0, 10'(v * 4), vt[v].qs, vt[v].sgn, 0);
      if (got_d.size() > g) chk("vec_word0", 64'(got_d[g]), 64'({4{vt[v].exp}}));
    end

    // Backpressure stall after first word.
    for (int i = 0; i < NPE; i++) pe_vals[i] = 32'(i * 37 - 200);
    drain(2, 10'h100, 5'd1, 1'b1, 0);

    // Start pulse while busy must not disturb the running drain.
    for (int i = 0; i < NPE; i++) pe_vals[i] = 32'(i * 1000 - 5000);
    drain(0, 10'h200, 5'd4, 1'b0, 1);

    // Reset mid-drain, then a fresh full drain.
    drain(0, 10'h300, 5'd0, 1'b1, 2);
    for (int i = 0; i < NPE; i++) pe_vals[i] = 32'(15 - i);
    drain(0, 10'h010, 5'd0, 1'b1, 0);

    // Address wrap.
    drain(0, 10'h3FE, 5'd0, 1'b0, 0);

    // Randomized drains with random backpressure.
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < NPE; i++)
        pe_vals[i] = $signed($urandom) >>> $urandom_range(0, 28);
      drain(1, 10'($urandom), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
